// File: rtl/uart_pkg.sv
// Shared UART constants and arbiter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//   BAUD_MAX     : clock cycles per UART bit, shared with uart_send
//   FRAME_CYCLES : arbiter hold-off after each valid pulse (start + 8 data + stop, plus margin)
//   CNT_W        : frame counter width, 2**CNT_W > FRAME_CYCLES
package uart_pkg;

    localparam int BAUD_MAX     = 10416;
    localparam int FRAME_CYCLES = 10 * BAUD_MAX + 2;
    localparam int CNT_W        = 17;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter.
// Latency: n/a (wires only).
// Backpressure: gnt is the only acceptance signal; req is held until gnt pulses.
//   en, req, data           : driven by the requesters (master)
//   gnt, tx_valid, tx_data,
//   busy                    : driven by the arbiter (slave)
interface uart_tx_arbiter_if #(
    parameter int N = 4
) ();

    logic             en;
    logic [N-1:0]     req;
    logic [8*N-1:0]   data;
    logic [N-1:0]     gnt;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             busy;

    modport master (
        output en, req, data,
        input  gnt, tx_valid, tx_data, busy
    );

    modport slave (
        input  en, req, data,
        output gnt, tx_valid, tx_data, busy
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1 (mod N).
// Latency: combinational, zero cycles.
// Backpressure: none; any=0 when no request is pending.
//   req  : per-requester request levels
//   last : index granted most recently
//   any  : at least one request pending
//   idx  : selected requester index (valid when any=1)
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [N-1:0] rot;
    int           sh;
    int           off;
    int           sum;

    // Duplicating req makes the right shift a rotation: bit k of rot is
    // requester (last+1+k) mod N, so the lowest set bit of rot is the winner.
    always_comb begin
        sh  = int'(last) + 1;
        rot = N'({req, req} >> sh);
        off = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
            end
        end
        sum = sh + off;
        if (sum >= N) begin
            sum = sum - N;
        end
    end

    assign any = |req;
    assign idx = IW'(sum);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send between N byte requesters.
// Latency: tx_valid/gnt one cycle after IDLE sees en=1 and req!=0.
// Backpressure: after each grant, holds off FRAME_CYCLES cycles (busy=1) since uart_send has no ready.
//   clk, rst          : clock, asynchronous active-high reset
//   bus.en            : allows new grants (an ongoing frame always completes)
//   bus.req/bus.data  : per-requester level request and byte
//   bus.gnt           : one-hot pulse, coincident with tx_valid
//   bus.tx_valid/
//   bus.tx_data       : drive uart_send valid/data
//   bus.busy          : high while waiting out the frame
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N            = 4,
    parameter int BAUD_MAX     = uart_pkg::BAUD_MAX,
    parameter int FRAME_CYCLES = 10 * BAUD_MAX + 2,
    parameter int CNT_W        = uart_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int               IW       = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [IW-1:0]    LAST_RST = IW'(N - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IW-1:0]    last, last_nxt;
    logic [N-1:0]     gnt_q, gnt_nxt;
    logic             vld_q, vld_nxt;
    logic [7:0]       txd_q, txd_nxt;
    logic             busy_q, busy_nxt;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic [N-1:0]     pick_oh;
    logic [7:0]       pick_dat;

    uart_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req  (bus.req),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // One-hot grant and byte mux for the picked index.
    always_comb begin
        pick_oh  = '0;
        pick_dat = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == pick_idx) begin
                pick_oh[i] = 1'b1;
                pick_dat   = bus.data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            last   <= LAST_RST;
            gnt_q  <= '0;
            vld_q  <= 1'b0;
            txd_q  <= 8'h00;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last   <= last_nxt;
            gnt_q  <= gnt_nxt;
            vld_q  <= vld_nxt;
            txd_q  <= txd_nxt;
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        gnt_nxt   = '0;
        vld_nxt   = 1'b0;
        txd_nxt   = txd_q;
        busy_nxt  = busy_q;
        case (state)
            ST_IDLE: begin
                if (bus.en && pick_any) begin
                    vld_nxt   = 1'b1;
                    gnt_nxt   = pick_oh;
                    txd_nxt   = pick_dat;
                    last_nxt  = pick_idx;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // en and req are deliberately ignored until the frame is over.
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.tx_valid = vld_q;
    assign bus.tx_data  = txd_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a short frame time.
// Reference model tracks the grant schedule as "next edge at which a grant is allowed".
// Directed scenarios followed by a randomized run with occasional mid-frame resets.
module tb_uart_tx_arbiter;

    localparam int TN = 4;
    localparam int TB = 4;
    localparam int TF = 10 * TB + 2;
    localparam int TW = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(TN)) bus ();

    uart_tx_arbiter #(
        .N            (TN),
        .BAUD_MAX     (TB),
        .FRAME_CYCLES (TF),
        .CNT_W        (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int            m_edge    = 0;
    int            m_next_ok = 0;
    int            m_gedge   = -1;
    int            m_last    = TN - 1;
    logic          m_gvld    = 1'b0;
    logic [TN-1:0] m_gnt     = '0;
    logic [7:0]    m_txd     = 8'h00;

    bit            drop_on_gnt = 0;
    bit            chk_gap     = 0;
    int            last_vld_edge = -1;
    logic [7:0]    obs_q[$];
    logic [TN-1:0] obs_g[$];
    int            busy_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_dat(input int i, input logic [7:0] v);
        bus.data[8*i +: 8] = v;
    endtask

    // Called at a negedge with inputs settled; returns at the next negedge.
    task automatic step();
        m_edge++;
        m_gvld = 1'b0;
        m_gnt  = '0;
        if (m_edge >= m_next_ok && bus.en && bus.req != '0) begin
            for (int k = 1; k <= TN; k++) begin
                int j;
                j = (m_last + k) % TN;
                if (bus.req[j]) begin
                    m_gvld    = 1'b1;
                    m_gnt     = '0;
                    m_gnt[j]  = 1'b1;
                    m_txd     = bus.data[8*j +: 8];
                    m_last    = j;
                    m_gedge   = m_edge;
                    m_next_ok = m_edge + TF + 1;
                    break;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("tx_valid", bus.tx_valid, m_gvld);
        chk("gnt", bus.gnt, m_gnt);
        chk("tx_data", bus.tx_data, m_txd);
        chk("busy", bus.busy, (m_gedge >= 0) && (m_edge - m_gedge < TF));
        if (bus.tx_valid) begin
            if (chk_gap && last_vld_edge >= 0)
                chk("pulse_gap", m_edge - last_vld_edge, TF + 1);
            last_vld_edge = m_edge;
            obs_q.push_back(bus.tx_data);
            obs_g.push_back(bus.gnt);
        end
        if (drop_on_gnt) begin
            for (int i = 0; i < TN; i++)
                if (m_gnt[i]) bus.req[i] = 1'b0;
        end
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_gnt", bus.gnt, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_gedge       = -1;
        m_last        = TN - 1;
        m_txd         = 8'h00;
        m_next_ok     = 0;
        m_gvld        = 1'b0;
        m_gnt         = '0;
        last_vld_edge = -1;
    endtask

    initial begin
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        @(negedge clk);
        do_reset();

        // single request, latency and busy length
        set_dat(0, 8'h41);
        bus.req     = 4'b0001;
        bus.en      = 1'b1;
        drop_on_gnt = 1;
        step();
        chk("t1_vld", bus.tx_valid, 1'b1);
        chk("t1_gnt", bus.gnt, 4'b0001);
        chk("t1_dat", bus.tx_data, 8'h41);
        busy_cnt = 0;
        repeat (TF + 5) begin
            if (bus.busy) busy_cnt++;
            step();
        end
        chk("t1_busy_len", busy_cnt, TF);

        // all requesting: strict rotation and exact spacing
        do_reset();
        for (int i = 0; i < TN; i++) set_dat(i, 8'h30 + 8'(i));
        bus.req     = '1;
        drop_on_gnt = 0;
        chk_gap     = 1;
        obs_q.delete();
        repeat (5 * (TF + 1)) step();
        chk_gap = 0;
        chk("t2_count", obs_q.size(), 5);
        for (int k = 0; k < 5; k++) chk("t2_byte", obs_q[k], 8'h30 + 8'(k % 4));

        // last=1, req=0101 -> 2 then 0
        do_reset();
        drop_on_gnt = 1;
        set_dat(1, 8'h55);
        bus.req = 4'b0010;
        step();
        repeat (TF) step();
        set_dat(0, 8'hAA);
        set_dat(2, 8'hBB);
        bus.req = 4'b0101;
        obs_g.delete();
        repeat (2 * (TF + 1)) step();
        chk("t3_count", obs_g.size(), 2);
        chk("t3_gnt0", obs_g[0], 4'b0100);
        chk("t3_gnt1", obs_g[1], 4'b0001);

        // lone requester 3 granted back-to-back
        do_reset();
        drop_on_gnt = 0;
        set_dat(3, 8'hC3);
        bus.req = 4'b1000;
        obs_g.delete();
        repeat (3 * (TF + 1)) step();
        chk("t4_count", obs_g.size(), 3);
        for (int k = 0; k < 3; k++) chk("t4_gnt", obs_g[k], 4'b1000);

        // en gating, and en dropping mid-frame
        do_reset();
        drop_on_gnt = 1;
        bus.en = 1'b0;
        set_dat(1, 8'h77);
        bus.req = 4'b0010;
        obs_q.delete();
        repeat (300) step();
        chk("t5_blocked", obs_q.size(), 0);
        bus.en = 1'b1;
        step();
        chk("t5_vld", bus.tx_valid, 1'b1);
        chk("t5_dat", bus.tx_data, 8'h77);
        repeat (10) step();
        bus.en  = 1'b0;
        bus.req = 4'b0010;
        busy_cnt = 0;
        repeat (TF + 20) begin
            if (bus.busy) busy_cnt++;
            step();
        end
        chk("t5_busy_len", busy_cnt, TF - 10);
        chk("t5_no_regrant", obs_q.size(), 1);

        // reset mid-frame, then requester 0 wins
        do_reset();
        bus.en = 1'b1;
        set_dat(2, 8'h22);
        bus.req = 4'b0100;
        step();
        repeat (20) step();
        for (int i = 0; i < TN; i++) set_dat(i, 8'h60 + 8'(i));
        bus.req = '1;
        do_reset();
        step();
        chk("t6_gnt", bus.gnt, 4'b0001);
        chk("t6_dat", bus.tx_data, 8'h60);

        // randomized traffic
        do_reset();
        drop_on_gnt = 1;
        repeat (3000) begin
            for (int i = 0; i < TN; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_dat(i, 8'($urandom));
                        bus.req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_send transmitter between N byte requesters using round-robin arbitration.
- uart_send has no busy/ready output, so this block issues its one-cycle valid pulse, then holds off for a full frame time before granting again.
- It sits between the application sources (key scanner, display echo, status reporter, ...) and uart_send. Its tx_valid and tx_data drive uart_send's valid and data inputs.

Parameters:
- N, 4, number of requesters (2..8).
- BAUD_MAX, 10416, clock cycles per UART bit (must match uart_send).
- FRAME_CYCLES, 10*BAUD_MAX+2 (104162), hold-off cycles after each tx_valid pulse.
- CNT_W, 17, frame counter width; must satisfy 2^CNT_W > FRAME_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  1 allows new grants; 0 blocks new grants but an in-progress frame still completes.
- req  input  N  per-requester level request; held until the matching gnt bit pulses.
- data  input  8*N  requester i byte on data[8i+7:8i]; stable while req[i]=1.
- gnt  output  N  one-hot, one-cycle pulse; the granted byte is consumed.
- tx_valid  output  1  one-cycle pulse to uart_send valid.
- tx_data  output  8  byte to uart_send data; valid when tx_valid=1, held afterwards.
- busy  output  1  1 while in WAIT.

Behaviour:
- Reset values: gnt=0, tx_valid=0, tx_data=8'h00, busy=0. Internally: state=IDLE, cnt=0, last=N-1, so requester 0 has first priority.
- States: IDLE and WAIT, 1-bit encoding from the package.
- IDLE, with en=1 and req!=0 at a clock edge:
  - Select index i, the first set req bit searching upward (modulo N) from last+1.
  - Register in the same edge: tx_valid<=1, gnt<=(1<<i), tx_data<=data[i], last<=i, cnt<=0, busy<=1, state<=WAIT.
- IDLE, with en=0 or req=0: stay in IDLE with outputs at rest values. tx_data holds its last value.
- WAIT: tx_valid<=0, gnt<=0, cnt<=cnt+1.
  - When cnt==FRAME_CYCLES-1: state<=IDLE, busy<=0, cnt<=0.
  - req and en are ignored in WAIT.
- Latency: tx_valid is high in the cycle after the first edge at which IDLE sees en=1 and req!=0.
- Pulse spacing: minimum FRAME_CYCLES+1 cycles between consecutive tx_valid rising edges. uart_send frames last 1+10*BAUD_MAX cycles, so it is always back in IDLE before the next valid.
- Fairness: under continuous requests from all N requesters, grant order is 0,1,...,N-1,0,...; no requester waits more than N frames.
- A requester that drops req before its grant is never granted. Its data is not captured.
- The same requester is granted back-to-back when it is the only one requesting.
- Simultaneous requests: exactly one gnt bit per grant, never more.
- A gnt pulse coincides exactly with tx_valid. The requester may change req and data from the following cycle.
- en falling during WAIT: the current frame completes; no new grant until en=1.
- rst mid-WAIT: the counter clears immediately and all outputs return to reset values. The shared rst also resets uart_send, so no partial frame is tracked.
- Width rules: cnt is a CNT_W-bit unsigned value compared against the truncated FRAME_CYCLES-1. The round-robin index computation wraps modulo N.

Decomposition:
- Shared package uart_pkg holds:
  - BAUD_MAX, also used by uart_send.
  - FRAME_CYCLES and CNT_W.
  - State encodings ST_IDLE and ST_WAIT.
- Sub-module uart_rr_pick: combinational round-robin picker.
  - Inputs: req[N-1:0], last.
  - Outputs: any, idx.
  - Implemented as a double-width rotate plus priority encoder.
- The top level contains the FSM, frame counter and output registers.

Test Plan:
- Reset then req=4'b0001, data0=8'h41, en=1 -> tx_valid and gnt=0001 for exactly one cycle, 1 cycle after the req edge; tx_data=8'h41; busy=1 for 104162 cycles.
- req=4'b1111 held, data=8'h30..8'h33 -> bytes 30,31,32,33,30 in order; consecutive tx_valid rising edges exactly 104163 cycles apart. With uart_send connected, the decoded dout stream equals the same bytes.
- last=1, req=4'b0101 -> gnt=0100 (index 2); next grant gnt=0001.
- Single requester 3 held high -> gnt=1000 on every grant; the other gnt bits never assert.
- en=0 with req=0010 -> no tx_valid for 300000 cycles. en raised -> tx_valid next cycle. en dropped mid-WAIT -> busy stays 1 for the full count, then no further grant.
- rst pulsed at cnt=5000 in WAIT -> busy=0, gnt=0, tx_valid=0 immediately; the next grant goes to requester 0 when req=1111.
